// File: rtl/inst_loader_pkg.sv
// Shared instruction-path definitions: widths, enable levels, loader states, ROM write payload.
package inst_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned ROM_ADDR_W = 32;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned IDX_W      = 2;

  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ldr_state_e;

  // One instruction-memory write: byte address plus word
  typedef struct packed {
    logic [ROM_ADDR_W-1:0] addr;
    logic [INST_W-1:0]     data;
  } rom_wr_t;

  // Requested word count limited to the configured maximum
  function automatic logic [CNT_W-1:0] clamp_words(input logic [CNT_W-1:0] req,
                                                   input logic [31:0]      max_words);
    if (32'(req) > max_words) begin
      return max_words[CNT_W-1:0];
    end
    return req;
  endfunction

endpackage

// File: rtl/inst_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; flags the word on its 4th byte.
module inst_byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_done_c,
  output logic [INST_W-1:0] word_c
);

  localparam int unsigned SHIFT_W = INST_W - BYTE_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(INST_W / BYTE_W - 1);

  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  // Next index / shift contents; the completed word is the shifter plus the current byte
  always_comb begin
    idx_d       = idx_q;
    shift_d     = shift_q;
    word_done_c = accept_i && (idx_q == LastIdx);
    word_c      = {shift_q, byte_i};
    if (clear_i) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (accept_i) begin
      idx_d   = idx_q + IDX_W'(1);
      shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_i};
    end
  end

  // Index and assembly register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Streams bytes from a source into instruction memory while holding the CPU in reset.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [ROM_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned           MAX_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic [CNT_W-1:0]      word_count_i,
  input  logic                  byte_valid_i,
  input  logic [BYTE_W-1:0]     byte_data_i,
  output logic                  byte_ready_o,
  output logic                  rom_ce_o,
  output logic                  rom_we_o,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  output logic [INST_W-1:0]     rom_data_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  ldr_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic [ROM_ADDR_W-1:0] addr_q, addr_d;
  logic                  last_q, last_d;
  rom_wr_t               wr_q, wr_d;
  logic                  we_q, we_d;
  logic                  ready_q, ready_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept_c;
  logic                  clear_c;
  logic                  word_done_c;
  logic [INST_W-1:0]     word_c;
  logic [CNT_W-1:0]      req_cnt_c;

  assign accept_c  = byte_valid_i && ready_q;
  assign req_cnt_c = clamp_words(word_count_i, MaxWords);

  inst_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_c),
    .accept_i    (accept_c),
    .byte_i      (byte_data_i),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  // Next state, address/count bookkeeping and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    addr_d    = addr_q;
    last_d    = last_q;
    wr_d      = wr_q;
    we_d      = DIS;
    clear_c   = DIS;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start_i) begin
          cnt_d   = req_cnt_c;
          words_d = '0;
          addr_d  = BASE_ADDR;
          last_d  = 1'b0;
          clear_c = EN;
          state_d = (req_cnt_c == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_q) begin
          // Final word is being written this cycle; hand the CPU back next cycle
          last_d  = 1'b0;
          state_d = ST_DONE;
        end else if (word_done_c) begin
          we_d      = EN;
          wr_d.addr = addr_q;
          wr_d.data = word_c;
          addr_d    = addr_q + ROM_ADDR_W'(4);
          words_d   = words_q + CNT_W'(1);
          last_d    = ((words_q + CNT_W'(1)) == cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d   = (state_d == ST_LOAD) && !last_d;
    busy_d    = (state_d == ST_LOAD);
    done_d    = (state_d == ST_DONE);
    cpu_rst_d = (state_d != ST_DONE);
  end

  // State, bookkeeping and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      words_q   <= '0;
      addr_q    <= BASE_ADDR;
      last_q    <= 1'b0;
      wr_q      <= '0;
      we_q      <= DIS;
      ready_q   <= DIS;
      cpu_rst_q <= EN;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign rom_ce_o     = we_q;
  assign rom_we_o     = we_q;
  assign rom_addr_o   = wr_q.addr;
  assign rom_data_o   = wr_q.data;
  assign cpu_rst_o    = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus random traffic against a byte-count model.
module tb_inst_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  logic        clk;
  logic        rst;
  logic        load_start_i;
  logic [15:0] word_count_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        rom_ce_o;
  logic        rom_we_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_o;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        done_o;

  inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .word_count_i (word_count_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .rom_ce_o     (rom_ce_o),
    .rom_we_o     (rom_we_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_o   (rom_data_o),
    .cpu_rst_o    (cpu_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a load needs 4*min(count,MAXW) bytes; every 4th byte yields one write
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_need   = 0;
  int          m_nacc   = 0;
  logic [7:0]  m_bytes[$];
  bit          e_we     = 1'b0;
  logic [31:0] e_addr   = 32'h0;
  logic [31:0] e_data   = 32'h0;

  // Observation log
  int          cyc_n       = 0;
  int          acc_obs     = 0;
  int          last_we_cyc = -1;
  int          fall_cyc    = -1;
  bit          prev_cpu_rst = 1'b1;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  // Drive one cycle, advance the model, compare every output
  task automatic cyc(input bit r, input bit st, input int wc, input bit v, input logic [7:0] d);
    bit acc_m;
    int n;
    rst          = r;
    load_start_i = st;
    word_count_i = 16'(wc);
    byte_valid_i = v;
    byte_data_i  = d;
    acc_m = v && m_active && (m_need > 0) && !r;
    if (v && byte_ready_o === 1'b1) acc_obs++;
    @(posedge clk);
    #1;
    cyc_n++;
    e_we = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_bytes.delete();
      e_addr   = 32'h0;
      e_data   = 32'h0;
    end else if (!m_active && st) begin
      n = (wc > MAXW) ? MAXW : wc;
      m_bytes.delete();
      m_nacc = 0;
      if (n == 0) begin
        m_done = 1'b1;
      end else begin
        m_active = 1'b1;
        m_done   = 1'b0;
        m_need   = 4 * n;
      end
    end else if (m_active && m_need == 0) begin
      m_active = 1'b0;
      m_done   = 1'b1;
    end else if (acc_m) begin
      m_bytes.push_back(d);
      m_nacc++;
      m_need--;
      if (m_bytes.size() == 4) begin
        e_we   = 1'b1;
        e_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        e_addr = BASE + 32'(4 * (m_nacc / 4 - 1));
        m_bytes.delete();
      end
    end
    chk("rom_we",     32'(rom_we_o),     32'(e_we));
    chk("rom_ce",     32'(rom_ce_o),     32'(e_we));
    chk("rom_addr",   rom_addr_o,        e_addr);
    chk("rom_data",   rom_data_o,        e_data);
    chk("byte_ready", 32'(byte_ready_o), 32'(m_active && (m_need > 0)));
    chk("busy",       32'(busy_o),       32'(m_active));
    chk("done",       32'(done_o),       32'(m_done));
    chk("cpu_rst",    32'(cpu_rst_o),    32'(!m_done));
    if (rom_we_o === 1'b1) begin
      wa.push_back(rom_addr_o);
      wd.push_back(rom_data_o);
      last_we_cyc = cyc_n;
    end
    if (prev_cpu_rst && cpu_rst_o === 1'b0) fall_cyc = cyc_n;
    prev_cpu_rst = (cpu_rst_o === 1'b1);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b0, 0, 1'b0, 8'h00);
  endtask

  logic [7:0] s38[8] = '{8'h34, 8'h01, 8'h00, 8'h10, 8'h24, 8'h02, 8'h00, 8'h20};

  initial begin
    rst          = 1'b1;
    load_start_i = 1'b0;
    word_count_i = 16'h0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;

    // Reset state
    repeat (3) cyc(1'b1, 1'b0, 0, 1'b0, 8'h00);
    chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("rst_addr", rom_addr_o, 32'h0);
    idle(2);

    // Two words back to back
    wa.delete(); wd.delete(); fall_cyc = -1;
    cyc(1'b0, 1'b1, 2, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 0, 1'b1, s38[i]);
    idle(3);
    chk("s38_nwr", 32'(wa.size()), 32'd2);
    chk("s38_a0", wa[0], 32'h0000_0000);
    chk("s38_d0", wd[0], 32'h3401_0010);
    chk("s38_a1", wa[1], 32'h0000_0004);
    chk("s38_d1", wd[1], 32'h2402_0020);
    chk("s38_fall", 32'(fall_cyc - last_we_cyc), 32'd1);

    // One word with valid toggling, started from DONE
    wa.delete(); wd.delete();
    cyc(1'b0, 1'b1, 1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 0, (i % 2) == 0, 8'($urandom));
    idle(2);
    chk("s39_nwr", 32'(wa.size()), 32'd1);

    // Zero-length load
    wa.delete(); wd.delete();
    cyc(1'b0, 1'b1, 0, 1'b0, 8'h00);
    chk("s40_done", 32'(done_o), 32'd1);
    chk("s40_cpu_rst", 32'(cpu_rst_o), 32'd0);
    idle(2);
    chk("s40_nwr", 32'(wa.size()), 32'd0);

    // Reset after six bytes, then reload one word
    wa.delete(); wd.delete();
    cyc(1'b0, 1'b1, 3, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 0, 1'b1, 8'($urandom));
    cyc(1'b1, 1'b0, 0, 1'b0, 8'h00);
    idle(2);
    chk("s41_nwr", 32'(wa.size()), 32'd1);
    chk("s41_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("s41_busy", 32'(busy_o), 32'd0);
    cyc(1'b0, 1'b1, 1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 1'b1, 8'(8'hA0 + i));
    idle(2);
    chk("s41_nwr2", 32'(wa.size()), 32'd2);
    chk("s41_addr", wa[1], BASE);
    chk("s41_data", wd[1], 32'hA0A1_A2A3);

    // Count clamped to MAXW; 17th byte refused
    wa.delete(); wd.delete(); acc_obs = 0;
    cyc(1'b0, 1'b1, 10, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 0, 1'b1, 8'($urandom));
    idle(2);
    chk("s42_nwr", 32'(wa.size()), 32'd4);
    chk("s42_last_addr", wa[3], 32'h0000_000C);
    chk("s42_accepted", 32'(acc_obs), 32'd16);

    // Start ignored mid-load, honoured in DONE
    wa.delete(); wd.delete();
    cyc(1'b0, 1'b1, 2, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 1'b1, 8'($urandom));
    cyc(1'b0, 1'b1, 1, 1'b1, 8'($urandom));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 1'b1, 8'($urandom));
    idle(2);
    chk("s43_done", 32'(done_o), 32'd1);
    cyc(1'b0, 1'b1, 1, 1'b0, 8'h00);
    chk("s43_cpu_rst", 32'(cpu_rst_o), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 1'b1, 8'($urandom));
    idle(2);
    chk("s43_nwr", 32'(wa.size()), 32'd3);
    chk("s43_a0", wa[0], 32'h0);
    chk("s43_a1", wa[1], 32'h4);
    chk("s43_a2", wa[2], BASE);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, st, v;
      int wc;
      r  = ($urandom_range(0, 149) == 0);
      st = ($urandom_range(0, 19) == 0);
      wc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6));
      v  = ($urandom_range(0, 3) != 0);
      cyc(r, st, wc, v, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
